instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (opcode, funct3, funct7, register indices, immediate, format) over a valid/ready handshake and emits the packed 32-bit instruction word through a 2-entry output buffer. It is the encode-side counterpart of the control unit's decode. It feeds instruction memory during test-program generation and self-check, so words produced here must decode back to the same fields.

## Interface
- No parameters. Buffer depth is fixed at 2.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  request fields valid
- in_ready  out  1  encoder can accept a request this cycle
- in_fmt  in  3  format: I=000, S=010, B=011, U=100, J=101, R=110; 001 and 111 are undefined
- in_op  in  7  opcode
- in_funct3  in  3  funct3, ignored for U and J
- in_funct7  in  7  funct7, used for R and for shift-immediates
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  full-width byte-offset/immediate, two's complement
- out_valid  out  1  out_instr is valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range or undefined format (see Configuration)
- out_count  out  16  number of words handed off since reset

## Operation
- Encoding per format; unused fields are 0:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Shift-immediate: fmt I, op 0010011, funct3 001 or 101. Bits [31:25] come from funct7; bits [24:20] come from imm[4:0].
- Undefined fmt: emit NOP 0x00000013.
- Encoding is combinational on the request. The encoded word and its error bit are written into the buffer on acceptance.
- Buffer: 2-entry FIFO of {instr, err}.
  - in_ready = !full.
  - out_valid = !empty.
  - out_instr and out_err are driven from the head entry.
- Accept = in_valid & in_ready. Handoff = out_valid & out_ready.
- Simultaneous accept and handoff:
  - When full, in_ready is 0, so only the handoff occurs.
  - When holding 1 entry, occupancy stays at 1.
  - When empty, only the accept occurs; there is no bypass.
- out_count increments on every handoff and wraps from 0xFFFF to 0x0000.
- Output stability: while out_valid=1 and out_ready=0, out_instr and out_err hold constant.

## Timing
- Latency: a request accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 word per cycle when out_ready=1.
- in_ready is registered (derived from occupancy only) and has no combinational path from out_ready.
- Reset values (applied asynchronously, immediately on rst=1): in_ready=1, out_valid=0, out_instr=0, out_err=0, out_count=0, buffer empty.
- Reset mid-operation discards all buffered entries.
- First accept is possible at the first rising edge after rst deasserts.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: out_err=1 for any entry where:
  - I/S: imm[31:11] is not all equal. Shift-immediate is exempt.
  - B: imm[31:12] is not all equal, or imm[0]=1.
  - J: imm[31:20] is not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - fmt is undefined.
- Even when out_err=1, the word is still emitted with truncated fields.
- ENCODER_RANGE_CHECK_EN undefined: no check logic is built; out_err is tied 0 and the buffer does not store an err bit.

## Structure
- Package encoder_pkg:
  - Format enum using the codes above.
  - Opcode constants (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_S=0100011, OP_B=1100011, OP_LUI=0110111, OP_AUIPC=0010111, OP_JAL=1101111).
  - NOP constant 0x00000013.
- Sub-module enc_fifo2: generic 2-entry FIFO holding the {instr, err} entry. Encode and range-check logic stays in instr_encoder.

## Test plan
- R, op 0110011, f3 0, f7 0, rd 3, rs1 1, rs2 2 -> out_instr 0x002081B3, err 0, out_count 1 after handoff.
- I, op 0010011, f3 0, rd 5, rs1 0, imm 0xFFFFFFFF -> 0xFFF00293, err 0.
- B, op 1100011, f3 001, rs1 1, rs2 2, imm 0xFFFFFFFC -> 0xFE209EE3, err 0.
- I, op 0010011, rd 5, imm 0x00000800:
  - With macro -> 0x80000293, err 1.
  - Without macro -> 0x80000293, err 0.
- out_ready=0, three back-to-back requests:
  - First two accepted; in_ready=0 after the second; third is held.
  - Raise out_ready: words emerge in order, one per cycle, and the third is accepted.
- Buffer full, rst pulsed between edges -> out_valid=0, in_ready=1, out_count=0 immediately; no stale words after release.

Source files
------------

// File: rtl/encoder_pkg.sv
// encoder_pkg: format codes, RV32I opcode constants and range helper for instr_encoder
package encoder_pkg;
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b010,
    FMT_B = 3'b011,
    FMT_U = 3'b100,
    FMT_J = 3'b101,
    FMT_R = 3'b110
  } fmt_e;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  // True when v[31:lo] are all the same bit, i.e. v fits a signed field of width lo+1
  function automatic logic sext_ok(input logic [31:0] v, input int lo);
    logic [31:0] s;
    s = $signed(v) >>> lo;
    return (s == '0) || (s == '1);
  endfunction
endpackage

// File: rtl/enc_fifo2.sv
// enc_fifo2: generic 2-entry FIFO; in_ready and out_valid depend only on registered occupancy
module enc_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;
  assign in_ready  = ~r_cnt[1];
  assign out_valid = |r_cnt;
  assign out_data  = r_mem[r_rp];
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // Storage, pointers and occupancy; reset clears the head so the output reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wp] <= in_data;
      r_wp  <= r_wp ^ w_push;
      r_rp  <= r_rp ^ w_pop;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into a word, buffered 2 deep; ENCODER_RANGE_CHECK_EN adds out_err
module instr_encoder
  import encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] out_count
);
  logic        w_shift;
  logic [11:0] w_iimm;
  logic [31:0] w_word;
  logic [15:0] r_count;
  assign w_shift = (in_fmt == FMT_I) && (in_op == OP_I) && (in_funct3[1:0] == 2'b01);
  assign w_iimm  = w_shift ? {in_funct7, in_imm[4:0]} : in_imm[11:0];
  assign w_word  =
    (in_fmt == FMT_R) ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op} :
    (in_fmt == FMT_I) ? {w_iimm, in_rs1, in_funct3, in_rd, in_op} :
    (in_fmt == FMT_S) ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op} :
    (in_fmt == FMT_B) ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_op} :
    (in_fmt == FMT_U) ? {in_imm[31:12], in_rd, in_op} :
    (in_fmt == FMT_J) ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op} :
    NOP;
`ifdef ENCODER_RANGE_CHECK_EN
  logic        w_err;
  logic [32:0] w_head;
  assign w_err =
    (in_fmt == FMT_I || in_fmt == FMT_S) ? (!w_shift && !sext_ok(in_imm, 11)) :
    (in_fmt == FMT_B) ? (!sext_ok(in_imm, 12) || in_imm[0]) :
    (in_fmt == FMT_J) ? (!sext_ok(in_imm, 20) || in_imm[0]) :
    (in_fmt == FMT_U) ? (|in_imm[11:0]) :
    (in_fmt == FMT_R) ? 1'b0 : 1'b1;
  enc_fifo2 #(.W(33)) u_fifo (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data({w_err, w_word}),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(w_head)
  );
  assign out_err   = w_head[32];
  assign out_instr = w_head[31:0];
`else
  enc_fifo2 #(.W(32)) u_fifo (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(w_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_instr)
  );
  assign out_err = 1'b0;
`endif
  assign out_count = r_count;
  // Count words handed to the consumer; wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= 16'd0;
    else if (out_valid && out_ready) r_count <= r_count + 16'd1;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with a scoreboard queue and a decoupled output monitor
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] out_count;
  logic [32:0] sb[$];
  logic [15:0] m_count = '0;
  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // e_rc is the err bit expected when the range check is built
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] e_word, input logic e_rc);
    logic e_err;
    bit done;
`ifdef ENCODER_RANGE_CHECK_EN
    e_err = e_rc;
`else
    e_err = 1'b0;
`endif
    done = 0;
    in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        sb.push_back({e_err, e_word});
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) m_count = '0;
      else begin
        chk("out_count", {16'd0, out_count}, {16'd0, m_count});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h expected no word", out_instr);
          end else begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("out_instr", out_instr, e[31:0]);
            chk("out_err", {31'd0, out_err}, {31'd0, e[32]});
          end
          m_count++;
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", {31'd0, out_err}, 0);
    chk("rst_out_count", {16'd0, out_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(3'b110, 7'b0110011, 3'd0, 7'd0,         5'd3, 5'd1, 5'd2, 32'h0,        32'h002081B3, 1'b0);
    send(3'b000, 7'b0010011, 3'd0, 7'd0,         5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0);
    send(3'b011, 7'b1100011, 3'd1, 7'd0,         5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE209EE3, 1'b0);
    send(3'b000, 7'b0010011, 3'd0, 7'd0,         5'd5, 5'd0, 5'd0, 32'h00000800, 32'h80000293, 1'b1);
    send(3'b010, 7'b0100011, 3'd2, 7'd0,         5'd0, 5'd2, 5'd5, 32'hFFFFFFF8, 32'hFE512C23, 1'b0);
    send(3'b100, 7'b0110111, 3'd0, 7'd0,         5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0);
    send(3'b100, 7'b0110111, 3'd0, 7'd0,         5'd1, 5'd0, 5'd0, 32'h12345001, 32'h123450B7, 1'b1);
    send(3'b101, 7'b1101111, 3'd0, 7'd0,         5'd1, 5'd0, 5'd0, 32'h00000008, 32'h008000EF, 1'b0);
    send(3'b101, 7'b1101111, 3'd0, 7'd0,         5'd1, 5'd0, 5'd0, 32'h00000007, 32'h006000EF, 1'b1);
    send(3'b000, 7'b0010011, 3'd5, 7'b0100000,   5'd5, 5'd6, 5'd0, 32'h00000803, 32'h40335293, 1'b0);
    send(3'b011, 7'b1100011, 3'd0, 7'd0,         5'd0, 5'd0, 5'd0, 32'h00000005, 32'h00000263, 1'b1);
    send(3'b001, 7'b0110011, 3'd7, 7'h7F,        5'd9, 5'd9, 5'd9, 32'h0,        32'h00000013, 1'b1);
    send(3'b111, 7'b0000000, 3'd0, 7'd0,         5'd0, 5'd0, 5'd0, 32'h0,        32'h00000013, 1'b1);
    drain();
    out_ready = 1'b0;
    send(3'b110, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
    send(3'b110, 7'b0110011, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 32'h0, 32'h406282B3 - 32'h80, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    chk("full_out_valid", {31'd0, out_valid}, 1);
    in_fmt = 3'b000; in_op = 7'b0010011; in_rd = 5'd7; in_rs1 = 5'd0; in_imm = 32'd1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("held_in_ready", {31'd0, in_ready}, 0);
    chk("held_out_instr", out_instr, 32'h002081B3);
    out_ready = 1'b1;
    send(3'b000, 7'b0010011, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd1, 32'h00100393, 1'b0);
    drain();
    out_ready = 1'b0;
    send(3'b100, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0);
    send(3'b100, 7'b0110111, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345137, 1'b0);
    chk("pre_rst_full", {31'd0, in_ready}, 0);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    chk("mid_rst_out_count", {16'd0, out_count}, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_empty", {31'd0, out_valid}, 0);
    send(3'b110, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
    drain();
    @(posedge clk); #1;
    chk("final_count", {16'd0, out_count}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
